stack_queue: RTL and testbench

Parametrised successor to the team's single-mode stack. One storage array serves as either a LIFO stack or a FIFO queue, selected by a mode input that can only change while the buffer is empty. Adds an occupancy count, a peek output, a registered read with a valid strobe, same-cycle push/pop pass-through, and sticky overflow/underflow error flags. It sits between the processor datapath and any unit that needs operand buffering.

---
 rtl/stack_queue.sv | 133 +++++++++++++
 tb/tb_stack_queue.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/stack_queue.sv
// Shared-storage LIFO/FIFO buffer with peek, registered read plus valid strobe, and sticky error flags.
// Pop-to-data_out latency is one clock; push-when-full and pop-when-empty are dropped and flagged, never stalled.
module stack_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
  input  logic             clear_err,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             mode_q, mode_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    lifo_ptr;
  logic [WIDTH-1:0] top_raw;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign lifo_ptr = wr_ptr_q - AW'(1);
  assign top_raw  = mode_q ? mem[rd_ptr_q] : mem[lifo_ptr];

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q & ~clear_err;
    underflow_d = underflow_q & ~clear_err;
    mode_d      = (empty && !push) ? mode : mode_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;

    unique case ({push, pop})
      2'b10: begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          underflow_d = 1'b1;
        end else begin
          data_out_d  = top_raw;
          out_valid_d = 1'b1;
          count_d     = count_q - CW'(1);
          if (mode_q) rd_ptr_d = rd_ptr_q + AW'(1);
          else        wr_ptr_d = lifo_ptr;
        end
      end
      2'b11: begin
        out_valid_d = 1'b1;
        if (empty) begin
          data_out_d = data_in;
        end else begin
          // The read of the old entry happens before the write lands, so a full FIFO can reuse rd==wr safely.
          data_out_d = top_raw;
          mem_we     = 1'b1;
          if (mode_q) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
          end else begin
            mem_waddr = lifo_ptr;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      mode_q      <= mode_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= data_in;
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign top       = empty ? '0 : top_raw;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_queue.sv
// Bench for stack_queue: directed scenarios then random traffic, checked each cycle against a queue-based model.
module tb_stack_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             resetN;
  logic             push, pop, mode, clear_err;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out, top;
  logic             out_valid, full, empty, overflow, underflow;
  logic [CW-1:0]    count;

  stack_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetN(resetN), .push(push), .pop(pop), .data_in(data_in),
    .mode(mode), .clear_err(clear_err), .data_out(data_out), .out_valid(out_valid),
    .top(top), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] mq[$];
  logic             m_mode, m_ov, m_un, m_vld;
  logic [WIDTH-1:0] m_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode = 1'b0; m_ov = 1'b0; m_un = 1'b0; m_vld = 1'b0; m_dout = '0;
  endtask

  task automatic model_step(input logic p, input logic o, input logic [WIDTH-1:0] d,
                            input logic m, input logic c);
    bit was_empty;
    bit was_full;
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == DEPTH);
    m_vld = 1'b0;
    m_ov  = m_ov & ~c;
    m_un  = m_un & ~c;
    if (p && !o) begin
      if (was_full) m_ov = 1'b1;
      else mq.push_back(d);
    end else if (!p && o) begin
      if (was_empty) m_un = 1'b1;
      else begin
        m_vld  = 1'b1;
        m_dout = m_mode ? mq.pop_front() : mq.pop_back();
      end
    end else if (p && o) begin
      m_vld = 1'b1;
      if (was_empty) m_dout = d;
      else begin
        m_dout = m_mode ? mq.pop_front() : mq.pop_back();
        mq.push_back(d);
      end
    end
    if (was_empty && !p) m_mode = m;
  endtask

  task automatic compare_all(input string tag);
    logic [WIDTH-1:0] exp_top;
    exp_top = (mq.size() == 0) ? '0 : (m_mode ? mq[0] : mq[$]);
    check({tag, ".count"},     32'(count),     32'(mq.size()));
    check({tag, ".full"},      32'(full),      32'(mq.size() == DEPTH));
    check({tag, ".empty"},     32'(empty),     32'(mq.size() == 0));
    check({tag, ".top"},       32'(top),       32'(exp_top));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
    check({tag, ".data_out"},  32'(data_out),  32'(m_dout));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ov));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_un));
  endtask

  task automatic cycle(input string tag, input logic p, input logic o,
                       input logic [WIDTH-1:0] d, input logic m, input logic c);
    @(negedge clk);
    push = p; pop = o; data_in = d; mode = m; clear_err = c;
    model_step(p, o, d, m, c);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  logic cur_mode;

  initial begin
    resetN = 1'b0; push = 0; pop = 0; data_in = '0; mode = 0; clear_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all("reset");
    @(negedge clk) resetN = 1'b1;

    // LIFO ordering
    cur_mode = 1'b0;
    cycle("lifo_push", 1, 0, 8'h11, 0, 0);
    cycle("lifo_push", 1, 0, 8'h22, 0, 0);
    cycle("lifo_push", 1, 0, 8'h33, 0, 0);
    repeat (3) cycle("lifo_pop", 0, 1, 8'h00, 0, 0);
    cycle("lifo_idle", 0, 0, 8'h00, 0, 0);

    // FIFO ordering; mode change while non-empty must be ignored
    cycle("set_fifo", 0, 0, 8'h00, 1, 0);
    cycle("fifo_push", 1, 0, 8'h11, 1, 0);
    cycle("fifo_push", 1, 0, 8'h22, 1, 0);
    cycle("fifo_push", 1, 0, 8'h33, 1, 0);
    cycle("fifo_pop", 0, 1, 8'h00, 1, 0);
    cycle("fifo_pop", 0, 1, 8'h00, 1, 0);
    cycle("mode_ign", 1, 0, 8'h44, 0, 0);
    cycle("mode_ign_pop", 0, 1, 8'h00, 0, 0);
    cycle("mode_ign_pop", 0, 1, 8'h00, 1, 0);

    // FIFO wrap, overflow
    for (int i = 0; i < 8; i++) cycle("wrap_fill", 1, 0, 8'hA0 + 8'(i), 1, 0);
    cycle("wrap_ovf", 1, 0, 8'hFF, 1, 0);
    cycle("wrap_clr", 0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 4; i++) cycle("wrap_pop", 0, 1, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) cycle("wrap_push", 1, 0, 8'hB0 + 8'(i), 1, 0);
    for (int i = 0; i < 8; i++) cycle("wrap_drain", 0, 1, 8'h00, 1, 0);

    // Underflow and clear_err precedence
    cycle("unf", 0, 1, 8'h00, 1, 0);
    cycle("unf_clr_set", 0, 1, 8'h00, 1, 1);
    cycle("unf_clr", 0, 0, 8'h00, 1, 1);

    // Simultaneous push/pop
    cycle("pass", 1, 1, 8'h5A, 1, 0);
    cycle("to_lifo", 0, 0, 8'h00, 0, 0);
    cycle("lp_push", 1, 0, 8'h01, 0, 0);
    cycle("lp_push", 1, 0, 8'h02, 0, 0);
    cycle("lp_both", 1, 1, 8'h03, 0, 0);
    cycle("lp_pop", 0, 1, 8'h00, 0, 0);
    cycle("lp_pop", 0, 1, 8'h00, 0, 0);
    cycle("to_fifo", 0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 8; i++) cycle("ff_fill", 1, 0, 8'hC0 + 8'(i), 1, 0);
    cycle("ff_both", 1, 1, 8'hD0, 1, 0);
    for (int i = 0; i < 8; i++) cycle("ff_drain", 0, 1, 8'h00, 1, 0);

    // Reset asserted mid-pop with five entries held
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1, 0, 8'h70 + 8'(i), 1, 1);
    @(negedge clk);
    push = 0; pop = 1; clear_err = 0;
    #2 resetN = 1'b0;
    model_reset();
    #1 compare_all("rst_async");
    @(posedge clk);
    #1 compare_all("rst_hold");
    @(negedge clk);
    resetN = 1'b1; pop = 0; mode = 0;

    // Random traffic
    cur_mode = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic p, o, c;
      p = ($urandom_range(0, 99) < 50);
      o = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 19) == 0) cur_mode = ~cur_mode;
      cycle("rand", p, o, 8'($urandom), cur_mode, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
